ex_mem_stage: RTL

Execute stage plus EX/MEM pipeline register for the 16-bit five-stage core. It sits directly downstream of the ID/EX register and consumes its outputs. Each cycle it forwards operands, runs the ALU and resolves branches and jumps, driving a same-cycle PC redirect. The execute result and MEM/WB control are then captured into a stall/flush-capable EX/MEM register feeding the memory stage.

---
 rtl/ex_pkg.sv | 77 +++++++
 rtl/ex_mem_stage_if.sv | 56 +++++
 rtl/alu16.sv | 34 +++
 rtl/ex_mem_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared encodings and the EX/MEM payload for the 16-bit execute stage.
package ex_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_SRA   = 4'd8,
        ALU_CMP   = 4'd9,
        ALU_SLT   = 4'd10,
        ALU_PASSA = 4'd11,
        ALU_PASSB = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_FWD1 = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2,
        SRC1_FWD2 = 2'd3
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_FWD2 = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_ONE  = 2'd2,
        SRC2_ZERO = 2'd3
    } src2_sel_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_EQZ    = 2'd1,
        COND_NEZ    = 2'd2,
        COND_NEVER  = 2'd3
    } br_cond_e;

    localparam logic [IDX_W-1:0] REG_T    = 4'd8;
    localparam logic [IDX_W-1:0] REG_SP   = 4'd9;
    localparam logic [IDX_W-1:0] REG_IH   = 4'd10;
    localparam logic [IDX_W-1:0] REG_RA   = 4'd11;
    localparam logic [IDX_W-1:0] REG_NONE = 4'd15;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [IDX_W-1:0]  dest_idx;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '{
        alu_result: '0,
        store_data: '0,
        dest_idx:   REG_NONE,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0
    };

    // A forwarding source matches only a real (non-15) index it is writing.
    function automatic logic fwd_hit(input logic [IDX_W-1:0] src,
                                     input logic [IDX_W-1:0] dest,
                                     input logic             we);
        return we && (src != REG_NONE) && (src == dest);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX-side inputs, MEM/WB forwarding source and EX/MEM outputs of the execute stage.
interface ex_mem_stage_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RIDX  = 4
);
    logic             STALL;
    logic             FLUSH;
    logic [WIDTH-1:0] pcIn;
    logic [WIDTH-1:0] data1In;
    logic [WIDTH-1:0] data2In;
    logic [WIDTH-1:0] immIn;
    logic [RIDX-1:0]  src1Idx;
    logic [RIDX-1:0]  src2Idx;
    logic [RIDX-1:0]  destIdxIn;
    logic [3:0]       aluOpIn;
    logic [1:0]       aluSrc1In;
    logic [1:0]       aluSrc2In;
    logic             branchIn;
    logic [1:0]       branchCondIn;
    logic             jumpIn;
    logic             rxToMemIn;
    logic             memReadIn;
    logic             memWriteIn;
    logic             memtoRegIn;
    logic             regWriteIn;
    logic             wbRegWrite;
    logic [RIDX-1:0]  wbDestIdx;
    logic [WIDTH-1:0] wbData;
    logic             redirect;
    logic [WIDTH-1:0] redirectTarget;
    logic [WIDTH-1:0] aluResultOut;
    logic [WIDTH-1:0] storeDataOut;
    logic [RIDX-1:0]  destIdxOut;
    logic             memReadOut;
    logic             memWriteOut;
    logic             memtoRegOut;
    logic             regWriteOut;

    modport master (
        output STALL, FLUSH, pcIn, data1In, data2In, immIn, src1Idx, src2Idx,
               destIdxIn, aluOpIn, aluSrc1In, aluSrc2In, branchIn, branchCondIn,
               jumpIn, rxToMemIn, memReadIn, memWriteIn, memtoRegIn, regWriteIn,
               wbRegWrite, wbDestIdx, wbData,
        input  redirect, redirectTarget, aluResultOut, storeDataOut, destIdxOut,
               memReadOut, memWriteOut, memtoRegOut, regWriteOut
    );

    modport slave (
        input  STALL, FLUSH, pcIn, data1In, data2In, immIn, src1Idx, src2Idx,
               destIdxIn, aluOpIn, aluSrc1In, aluSrc2In, branchIn, branchCondIn,
               jumpIn, rxToMemIn, memReadIn, memWriteIn, memtoRegIn, regWriteIn,
               wbRegWrite, wbDestIdx, wbData,
        output redirect, redirectTarget, aluResultOut, storeDataOut, destIdxOut,
               memReadOut, memWriteOut, memtoRegOut, regWriteOut
    );
endinterface

// File: rtl/alu16.sv
// Combinational ALU: A/B/op -> result, modulo 2^WIDTH.
module alu16
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y
);
    logic [3:0] shamt;

    always_comb begin
        shamt = b[3:0];
        y     = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOT:   y = ~a;
            ALU_SLL:   y = a << shamt;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
            ALU_CMP:   y = WIDTH'(a != b);
            ALU_SLT:   y = WIDTH'($signed(a) < $signed(b));
            ALU_PASSA: y = a;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end
endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect, and the EX/MEM register.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned RIDX  = IDX_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    ex_mem_stage_if.slave bus
);
    exmem_t exmem_q;
    exmem_t exmem_d;

    logic [WIDTH-1:0] fwd1;
    logic [WIDTH-1:0] fwd2;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_y;
    logic             exmem_fwd_we;
    logic             cond_ok;
    logic             taken;

    // EX/MEM wins over MEM/WB; a load in EX/MEM never forwards (hazard unit bubbles).
    always_comb begin
        exmem_fwd_we = exmem_q.reg_write & ~exmem_q.mem_read;

        fwd1 = bus.data1In;
        if (fwd_hit(bus.src1Idx, exmem_q.dest_idx, exmem_fwd_we))
            fwd1 = exmem_q.alu_result;
        else if (fwd_hit(bus.src1Idx, bus.wbDestIdx, bus.wbRegWrite))
            fwd1 = bus.wbData;

        fwd2 = bus.data2In;
        if (fwd_hit(bus.src2Idx, exmem_q.dest_idx, exmem_fwd_we))
            fwd2 = exmem_q.alu_result;
        else if (fwd_hit(bus.src2Idx, bus.wbDestIdx, bus.wbRegWrite))
            fwd2 = bus.wbData;
    end

    always_comb begin
        op_a = fwd1;
        case (bus.aluSrc1In)
            SRC1_FWD1: op_a = fwd1;
            SRC1_PC:   op_a = bus.pcIn;
            SRC1_ZERO: op_a = '0;
            SRC1_FWD2: op_a = fwd2;
            default:   op_a = fwd1;
        endcase

        op_b = fwd2;
        case (bus.aluSrc2In)
            SRC2_FWD2: op_b = fwd2;
            SRC2_IMM:  op_b = bus.immIn;
            SRC2_ONE:  op_b = WIDTH'(1);
            SRC2_ZERO: op_b = '0;
            default:   op_b = fwd2;
        endcase
    end

    alu16 #(.WIDTH(WIDTH)) u_alu (
        .a  (op_a),
        .b  (op_b),
        .op (bus.aluOpIn),
        .y  (alu_y)
    );

    // Jump beats branch; a stalled instruction redirects on the cycle it finally advances.
    always_comb begin
        cond_ok = 1'b0;
        case (bus.branchCondIn)
            COND_ALWAYS: cond_ok = 1'b1;
            COND_EQZ:    cond_ok = (fwd1 == '0);
            COND_NEZ:    cond_ok = (fwd1 != '0);
            COND_NEVER:  cond_ok = 1'b0;
            default:     cond_ok = 1'b0;
        endcase
        taken              = bus.jumpIn | (bus.branchIn & cond_ok);
        bus.redirect       = taken & ~bus.STALL;
        bus.redirectTarget = bus.jumpIn ? fwd1 : (bus.pcIn + bus.immIn);
    end

    always_comb begin
        exmem_d = exmem_q;
        if (bus.STALL) begin
            exmem_d = exmem_q;
        end else if (bus.FLUSH) begin
            exmem_d = EXMEM_BUBBLE;
        end else begin
            exmem_d.alu_result = alu_y;
            exmem_d.store_data = bus.rxToMemIn ? fwd1 : fwd2;
            exmem_d.dest_idx   = bus.destIdxIn;
            exmem_d.mem_read   = bus.memReadIn;
            exmem_d.mem_write  = bus.memWriteIn;
            exmem_d.mem_to_reg = bus.memtoRegIn;
            exmem_d.reg_write  = bus.regWriteIn;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) exmem_q <= EXMEM_BUBBLE;
        else        exmem_q <= exmem_d;
    end

    assign bus.aluResultOut = exmem_q.alu_result;
    assign bus.storeDataOut = exmem_q.store_data;
    assign bus.destIdxOut   = exmem_q.dest_idx;
    assign bus.memReadOut   = exmem_q.mem_read;
    assign bus.memWriteOut  = exmem_q.mem_write;
    assign bus.memtoRegOut  = exmem_q.mem_to_reg;
    assign bus.regWriteOut  = exmem_q.reg_write;

endmodule
